// File: rtl/decode_out_capture_pkg.sv
// Shared types and layout helpers for the decode-output capture buffer.
package decode_out_capture_pkg;

  // Record width for a given datapath width: 6 + 1 + 2 control bits plus IR and NPC.
  function automatic int unsigned rec_width(input int unsigned data_w);
    return 9 + 2 * data_w;
  endfunction

  // Field offsets and record struct describe the default 16-bit datapath.
  localparam int unsigned DefDataW = 16;
  localparam int unsigned NPC_LSB  = 0;
  localparam int unsigned IR_LSB   = NPC_LSB + DefDataW;
  localparam int unsigned W_LSB    = IR_LSB + DefDataW;
  localparam int unsigned M_LSB    = W_LSB + 2;
  localparam int unsigned E_LSB    = M_LSB + 1;

  typedef struct packed {
    logic [5:0]          e_cntrl;
    logic                m_cntrl;
    logic [1:0]          w_cntrl;
    logic [DefDataW-1:0] instr_reg;
    logic [DefDataW-1:0] npc_out;
  } decode_rec_t;

  typedef enum logic {CAPTURE_ALL, CAPTURE_CHANGE} capture_mode_e;

endpackage

// File: rtl/decode_out_capture_fifo.sv
// Generic synchronous FIFO with flush; a push into a full FIFO is accepted when a
// pop happens in the same cycle.
module capture_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;
  logic             push_ok, pop_ok;

  // Qualify push/pop against occupancy.
  always_comb begin
    full_o  = (count_q == (PtrW+1)'(DEPTH));
    empty_o = (count_q == '0);
    pop_ok  = pop_i && !empty_o;
    push_ok = push_i && (!full_o || pop_ok);
    rdata_o = mem_q[rptr_q];
    count_o = count_q;
  end

  // Pointer and occupancy state; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i && !rst_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/decode_out_capture.sv
// Timestamped capture buffer for the LC3 decode-stage output bundle.
module decode_out_capture
  import decode_out_capture_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TS_W        = 16,
  parameter int unsigned CHANGE_ONLY = 0,
  localparam int unsigned REC_W      = rec_width(DATA_W)
) (
  input  logic                   clock_s,
  input  logic                   reset_s,
  input  logic [5:0]             e_cntrl_s,
  input  logic                   m_cntrl_s,
  input  logic [1:0]             w_cntrl_s,
  input  logic [DATA_W-1:0]      Instr_Reg_s,
  input  logic [DATA_W-1:0]      npc_out_s,
  input  logic                   en_de_s,
  input  logic                   clear_s,
  output logic                   out_valid_s,
  input  logic                   out_ready_s,
  output logic [REC_W-1:0]       out_rec_s,
  output logic [TS_W-1:0]        out_ts_s,
  output logic [$clog2(DEPTH):0] count_s,
  output logic                   overflow_s,
  output logic [15:0]            drop_cnt_s
);

  localparam capture_mode_e Mode = (CHANGE_ONLY != 0) ? CAPTURE_CHANGE : CAPTURE_ALL;

  logic [TS_W-1:0]       ts_q;
  logic [REC_W-1:0]      ref_q;
  logic                  ref_valid_q;
  logic                  overflow_q;
  logic [15:0]           drop_cnt_q;
  logic [REC_W-1:0]      rec;
  logic                  req, pop, drop, full, empty;
  logic [TS_W+REC_W-1:0] head;

  // Pack the bundle and decide whether this cycle requests a capture.
  always_comb begin
    rec  = {e_cntrl_s, m_cntrl_s, w_cntrl_s, Instr_Reg_s, npc_out_s};
    req  = en_de_s && ((Mode == CAPTURE_ALL) || !ref_valid_q || (rec != ref_q));
    pop  = !empty && out_ready_s;
    drop = req && full && !pop;
  end

  capture_fifo #(
    .WIDTH (TS_W + REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock_s),
    .rst_i   (reset_s),
    .flush_i (clear_s),
    .push_i  (req),
    .wdata_i ({ts_q, rec}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_s)
  );

  // Free-running timestamp; only reset restarts it.
  always_ff @(posedge clock_s) begin
    if (reset_s) ts_q <= '0;
    else         ts_q <= ts_q + TS_W'(1);
  end

  // Change-filter reference, loaded on every request even when the push is dropped.
  always_ff @(posedge clock_s) begin
    if (reset_s || clear_s) begin
      ref_valid_q <= 1'b0;
      ref_q       <= '0;
    end else if (req) begin
      ref_valid_q <= 1'b1;
      ref_q       <= rec;
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clock_s) begin
    if (reset_s || clear_s) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  // Head outputs read as zero while the FIFO is empty.
  always_comb begin
    out_valid_s = !empty;
    out_rec_s   = empty ? '0 : head[REC_W-1:0];
    out_ts_s    = empty ? '0 : head[TS_W+REC_W-1:REC_W];
    overflow_s  = overflow_q;
    drop_cnt_s  = drop_cnt_q;
  end

endmodule

// File: tb/tb_decode_out_capture.sv
// Bench for decode_out_capture: two instances (capture-all with 4-bit timestamps,
// change-only with 16-bit timestamps) share stimulus and are checked every cycle
// against a queue-based model, plus directed literal checks.
module tb_decode_out_capture;

  logic        clock = 1'b0;
  logic        rst, en, clr, rdy;
  logic [5:0]  e;
  logic        m;
  logic [1:0]  w;
  logic [15:0] ir, npc;

  logic        v0, v1, ov0, ov1;
  logic [40:0] r0, r1;
  logic [3:0]  t0;
  logic [15:0] t1, dc0, dc1;
  logic [3:0]  c0, c1;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  decode_out_capture #(.DATA_W(16), .DEPTH(8), .TS_W(4), .CHANGE_ONLY(0)) dut0 (
    .clock_s(clock), .reset_s(rst), .e_cntrl_s(e), .m_cntrl_s(m), .w_cntrl_s(w),
    .Instr_Reg_s(ir), .npc_out_s(npc), .en_de_s(en), .clear_s(clr),
    .out_valid_s(v0), .out_ready_s(rdy), .out_rec_s(r0), .out_ts_s(t0),
    .count_s(c0), .overflow_s(ov0), .drop_cnt_s(dc0)
  );

  decode_out_capture #(.DATA_W(16), .DEPTH(8), .TS_W(16), .CHANGE_ONLY(1)) dut1 (
    .clock_s(clock), .reset_s(rst), .e_cntrl_s(e), .m_cntrl_s(m), .w_cntrl_s(w),
    .Instr_Reg_s(ir), .npc_out_s(npc), .en_de_s(en), .clear_s(clr),
    .out_valid_s(v1), .out_ready_s(rdy), .out_rec_s(r1), .out_ts_s(t1),
    .count_s(c1), .overflow_s(ov1), .drop_cnt_s(dc1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {logic [40:0] rec; logic [15:0] ts;} ent_t;
  ent_t        q0[$], q1[$];
  int unsigned mts [2];
  logic [40:0] mref [2];
  bit          mrv [2];
  bit          mov [2];
  int unsigned mdc [2];
  bit          started = 0;
  logic [40:0] mrec;
  bit          mreq, mpop;

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction
  function automatic ent_t qfront(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction
  function automatic void qpop(input int k);
    if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endfunction
  function automatic void qpush(input int k, input ent_t x);
    if (k == 0) q0.push_back(x); else q1.push_back(x);
  endfunction
  function automatic void qclear(input int k);
    if (k == 0) q0.delete(); else q1.delete();
  endfunction

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        qclear(k); mts[k] = 0; mrv[k] = 0; mov[k] = 0; mdc[k] = 0;
      end else begin
        mrec = {e, m, w, ir, npc};
        mreq = en && (k == 0 || !mrv[k] || mrec != mref[k]);
        mpop = (qsize(k) > 0) && rdy;
        if (clr) begin
          qclear(k); mov[k] = 0; mdc[k] = 0; mrv[k] = 0;
        end else begin
          if (mreq) begin mref[k] = mrec; mrv[k] = 1; end
          if (mpop) qpop(k);
          if (mreq) begin
            if (qsize(k) < 8) qpush(k, '{rec: mrec, ts: 16'(mts[k])});
            else begin
              mov[k] = 1;
              if (mdc[k] < 65535) mdc[k]++;
            end
          end
        end
        mts[k] = (mts[k] + 1) % ((k == 0) ? 16 : 65536);
      end
    end
    if (rst) started = 1;
  end

  // Per-cycle compare of both instances against the model.
  always @(negedge clock) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        logic        ev;
        logic [40:0] er;
        logic [15:0] et;
        ev = qsize(k) > 0;
        er = ev ? qfront(k).rec : '0;
        et = ev ? qfront(k).ts : '0;
        chk($sformatf("d%0d_valid", k), (k == 0) ? 64'(v0) : 64'(v1), 64'(ev));
        chk($sformatf("d%0d_rec", k), (k == 0) ? 64'(r0) : 64'(r1), 64'(er));
        chk($sformatf("d%0d_ts", k), (k == 0) ? 64'(t0) : 64'(t1), 64'(et));
        chk($sformatf("d%0d_count", k), (k == 0) ? 64'(c0) : 64'(c1), 64'(qsize(k)));
        chk($sformatf("d%0d_ovf", k), (k == 0) ? 64'(ov0) : 64'(ov1), 64'(mov[k]));
        chk($sformatf("d%0d_drops", k), (k == 0) ? 64'(dc0) : 64'(dc1), 64'(mdc[k]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; rdy = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 0; clr = 0; rdy = 0; e = '0; m = 0; w = '0; ir = '0; npc = '0;
    step(); step();
    rst = 1'b0;
    chk("reset_count", 64'(c0), 64'd0);
    chk("reset_valid", 64'(v0), 64'd0);
    chk("reset_rec", 64'(r0), 64'd0);
    chk("reset_ts", 64'(t0), 64'd0);
    chk("reset_drops", 64'(dc0), 64'd0);

    // Basic capture and in-order drain with consecutive timestamps
    en = 1; ir = 16'h1234; step();
    ir = 16'h5678; step();
    ir = 16'h9ABC; step();
    en = 0;
    chk("basic_count", 64'(c0), 64'd3);
    chk("basic_valid", 64'(v0), 64'd1);
    chk("basic_ir0", 64'(r0[31:16]), 64'h1234);
    chk("basic_ts0", 64'(t0), 64'd0);
    rdy = 1; step();
    chk("basic_ir1", 64'(r0[31:16]), 64'h5678);
    chk("basic_ts1", 64'(t0), 64'd1);
    step();
    chk("basic_ts2", 64'(t0), 64'd2);
    step();
    chk("basic_empty", 64'(v0), 64'd0);
    rdy = 0;

    // Timestamp wrap (4-bit) then reset with three entries pending
    do_reset();
    repeat (14) step();
    en = 1; ir = 16'hA; step(); ir = 16'hB; step(); ir = 16'hC; step();
    chk("wrap_ts14", 64'(t0), 64'd14);
    rdy = 1; ir = 16'hD; step();
    chk("wrap_ts15", 64'(t0), 64'd15);
    ir = 16'hE; step();
    chk("wrap_ts0", 64'(t0), 64'd0);
    chk("wrap_count", 64'(c0), 64'd3);
    rdy = 0; en = 0; rst = 1; step(); rst = 0;
    chk("midrst_count", 64'(c0), 64'd0);
    chk("midrst_valid", 64'(v0), 64'd0);
    en = 1; step(); en = 0;
    chk("midrst_ts_restart", 64'(t0), 64'd0);

    // Overflow: ten captures into eight slots
    do_reset();
    for (int i = 0; i < 10; i++) begin en = 1; ir = 16'(i); step(); end
    en = 0;
    chk("ovf_count", 64'(c0), 64'd8);
    chk("ovf_flag", 64'(ov0), 64'd1);
    chk("ovf_drops", 64'(dc0), 64'd2);
    rdy = 1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_order%0d", i), 64'(r0[31:16]), 64'(i));
      step();
    end
    chk("ovf_drained", 64'(v0), 64'd0);
    rdy = 0;

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) begin en = 1; ir = 16'h100 + 16'(i); step(); end
    ir = 16'h1FF; rdy = 1; step();
    en = 0; rdy = 0;
    chk("fullpop_count", 64'(c0), 64'd8);
    chk("fullpop_ovf", 64'(ov0), 64'd0);
    rdy = 1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fullpop_order%0d", i), 64'(r0[31:16]),
          (i < 7) ? 64'(16'h101 + 16'(i)) : 64'h1FF);
      step();
    end
    rdy = 0;

    // Change filter on the change-only instance
    do_reset();
    en = 1; ir = 16'h1020; npc = 16'h3001;
    repeat (5) step();
    ir = 16'h1021; step();
    en = 0;
    chk("chg_count", 64'(c1), 64'd2);
    chk("chg_ts_first", 64'(t1), 64'd0);
    chk("chg_ir_first", 64'(r1[31:16]), 64'h1020);
    chk("chg_all_count", 64'(c0), 64'd6);
    rdy = 1; step(); rdy = 0;
    chk("chg_ir_second", 64'(r1[31:16]), 64'h1021);
    chk("chg_ts_second", 64'(t1), 64'd5);
    npc = '0;

    // Clear overrides a same-cycle push and pop
    do_reset();
    for (int i = 0; i < 4; i++) begin en = 1; ir = 16'h40 + 16'(i); step(); end
    chk("clr_pre_count", 64'(c0), 64'd4);
    clr = 1; rdy = 1; ir = 16'h50; step();
    clr = 0; rdy = 0; en = 0;
    chk("clr_count", 64'(c0), 64'd0);
    chk("clr_valid", 64'(v0), 64'd0);
    chk("clr_drops", 64'(dc0), 64'd0);
    en = 1; ir = 16'h55; step(); en = 0;
    chk("clr_ts_runs", 64'(t0), 64'd5);
    chk("clr_ts_runs1", 64'(t1), 64'd5);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      int unsigned p;
      p   = $urandom_range(0, 99);
      en  = ($urandom_range(0, 99) < 70);
      rdy = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 30 : 75));
      clr = (p < 2);
      rst = (p == 99);
      ir  = 16'h3000 + 16'($urandom_range(0, 3));
      npc = 16'h0200 + 16'($urandom_range(0, 1));
      e   = 6'($urandom_range(0, 1));
      m   = 1'($urandom_range(0, 1));
      w   = 2'($urandom_range(0, 3));
      step();
    end
    rst = 0; en = 0; clr = 0; rdy = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_out_capture.md
# decode_out_capture

Parametrised capture buffer for the LC3 decode-stage output bundle: `e_cntrl`, `m_cntrl`, `w_cntrl`, `Instr_Reg` and `npc_out`.
- On every cycle with `en_de_s` high, the bundle is timestamped and pushed into a DEPTH-entry FIFO, either unconditionally or only when it changed.
- The FIFO drains through a valid/ready port.
- It sits beside the decode stage and gives the environment and on-chip debug a lossless or loss-flagged trace of decode results.

## Interface
- `DATA_W`, 16: width of `Instr_Reg_s` and `npc_out_s`.
- `DEPTH`, 8: FIFO entries; a power of two, ≥2.
- `TS_W`, 16: timestamp width.
- `CHANGE_ONLY`, 0: 0 captures every enabled cycle; 1 captures only when the bundle differs from the last reference.
- `clock_s` in 1: clock; all logic is rising-edge.
- `reset_s` in 1: reset, synchronous and active-high.
- `e_cntrl_s` in 6: decode execute control.
- `m_cntrl_s` in 1: decode memory control.
- `w_cntrl_s` in 2: decode writeback control.
- `Instr_Reg_s` in DATA_W: decoded instruction.
- `npc_out_s` in DATA_W: next PC.
- `en_de_s` in 1: decode enable; capture qualifier.
- `clear_s` in 1: synchronous flush.
- `out_valid_s` out 1: head entry valid.
- `out_ready_s` in 1: consumer accepts the head entry.
- `out_rec_s` out REC_W: head record, where REC_W = 9+2·DATA_W.
- `out_ts_s` out TS_W: head timestamp.
- `count_s` out $clog2(DEPTH)+1: occupancy.
- `overflow_s` out 1: sticky; at least one capture was dropped.
- `drop_cnt_s` out 16: saturating count of dropped captures.

## Operation
- **Record packing:** MSB→LSB as {e_cntrl, m_cntrl, w_cntrl, Instr_Reg, npc_out}.
- **Timestamp:** a free-running TS_W counter. It is 0 on reset, increments every cycle, and wraps from 2^TS_W−1 to 0. It is not affected by `clear_s`. A captured entry stores the counter value from its sample cycle.
- **Capture request:** raised when `en_de_s`=1, and additionally, in CHANGE_ONLY mode, when either condition holds:
  - `ref_valid`=0, or
  - the packed bundle ≠ the reference register.
- **Reference register:** every capture request loads the reference register and sets `ref_valid`, even if the push is then dropped.
- **Pop:** occurs when `out_valid_s` && `out_ready_s`.
- **Push:** occurs when a request is raised and either (`count_s` < DEPTH) or (pop in the same cycle).
  - A full FIFO with a simultaneous pop accepts the push; occupancy stays at DEPTH.
- **Drop:** a request with FIFO full and no pop.
  - Sets `overflow_s`.
  - Increments `drop_cnt_s`, which saturates at 0xFFFF.
- **Clear:** `clear_s` empties the FIFO and zeroes `overflow_s`, `drop_cnt_s` and `ref_valid`. It overrides a same-cycle push and pop.
- **Order:** FIFO order is strict; `out_rec_s` and `out_ts_s` hold stable while `out_valid_s`=1 and `out_ready_s`=0.
- **Pointers:** read and write pointers are $clog2(DEPTH) bits and wrap naturally.

## Timing
- **Reset values:**
  - `out_valid_s`=0, `count_s`=0, `overflow_s`=0, `drop_cnt_s`=0.
  - `out_rec_s`=0 and `out_ts_s`=0 while the FIFO is empty.
  - Timestamp=0, `ref_valid`=0.
- **Latency:** a bundle sampled at edge N into an empty FIFO gives `out_valid_s`=1 after edge N, i.e. in cycle N+1; there is no fall-through within the sample cycle.
- **Throughput:** one push and one pop per cycle; `count_s` is unchanged on a simultaneous push and pop.
- **Reset mid-operation:** `reset_s` asserted while entries are pending discards them. Outputs return to reset values after that edge.
- **Consumer:** `out_ready_s` may be high while `out_valid_s`=0; this has no effect.

## Structure
- Package `decode_out_capture_pkg` holds:
  - the REC_W function of DATA_W;
  - field offset localparams (NPC_LSB, IR_LSB, W_LSB, M_LSB, E_LSB);
  - the typedef of the packed decode record struct;
  - the mode enum {CAPTURE_ALL, CAPTURE_CHANGE}.
- One sub-module, `capture_fifo`: a generic synchronous FIFO with parameters WIDTH and DEPTH, push/pop ports, full/empty and count outputs, full-with-pop accept, and flush.
- The top level contains the timestamp counter, change filter, reference register, drop accounting and record packing.

## Test plan
- **Basic capture:** after reset, drive `en_de_s`=1 for 3 cycles with IR=0x1234/0x5678/0x9ABC and `out_ready_s`=0.
  - `count_s`=3, `out_valid_s`=1, IR field of `out_rec_s`=0x1234.
  - The timestamps are consecutive.
- **Overflow:** with DEPTH=8, apply 10 enabled cycles with `out_ready_s`=0.
  - `count_s`=8, `overflow_s`=1, `drop_cnt_s`=2.
  - Draining returns the first 8 records in order.
- **Full with pop:** fill to 8, then issue a push and a pop in the same cycle.
  - `count_s` stays 8, `overflow_s` stays 0, and the new record is last out.
- **Change filter:** with CHANGE_ONLY=1, drive the same bundle (IR=0x1020, npc=0x3001) for 5 enabled cycles, then IR=0x1021.
  - Exactly 2 entries result; the first timestamp is the first sample cycle.
- **Clear vs push/pop:** assert `clear_s` with `en_de_s`=1 and `out_ready_s`=1 while `count_s`=4.
  - The next cycle shows `count_s`=0, `out_valid_s`=0 and `drop_cnt_s`=0; the timestamp keeps incrementing.
- **Wrap and mid-run reset:** with TS_W=4, capture across the timestamp wrap, then assert reset with 3 entries pending.
  - Stored timestamps are 14, 15, 0.
  - After reset: `count_s`=0, `out_valid_s`=0, and the timestamp restarts at 0.
